// File: rtl/zports_pkg.sv
// Shared constants and types for the ZX-bus port control register bank.
package zports_pkg;

  localparam int unsigned ADDR_W = 2;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned IRQ_W  = 2;

  // Register addresses inside the port window; 0 is owned by the SL811 data path.
  localparam logic [ADDR_W-1:0] REG_DATA = 2'd0;
  localparam logic [ADDR_W-1:0] REG_CFG  = 2'd1;
  localparam logic [ADDR_W-1:0] REG_IRQ  = 2'd2;
  localparam logic [ADDR_W-1:0] REG_MASK = 2'd3;

  // CFG register bit positions.
  localparam int unsigned CFG_WIN_LO = 0;
  localparam int unsigned CFG_WIN_HI = 1;
  localparam int unsigned CFG_ENA    = 4;
  localparam int unsigned CFG_SL_RST = 6;
  localparam int unsigned CFG_W_RST  = 7;

  // IRQ / MASK register bit positions.
  localparam int unsigned IRQ_W5300 = 0;
  localparam int unsigned IRQ_SL811 = 1;

  // Bus write captured while the synchronised strobe is low.
  typedef struct packed {
    logic              wrena;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_hold_t;

  // Assemble the CFG read-back value; the reset-request bits reflect pulse activity.
  function automatic logic [DATA_W-1:0] cfg_rd(
    input logic [1:0] win,
    input logic       ena,
    input logic       sl_busy,
    input logic       w_busy
  );
    logic [DATA_W-1:0] v;
    v = '0;
    v[CFG_WIN_HI:CFG_WIN_LO] = win;
    v[CFG_ENA]               = ena;
    v[CFG_SL_RST]            = sl_busy;
    v[CFG_W_RST]             = w_busy;
    return v;
  endfunction

endpackage

// File: rtl/zports_ctrl_rst_pulse.sv
// Timed chip-reset generator: loadable down-counter that saturates at zero.
module rst_pulse #(
  parameter int unsigned RST_CYCLES = 64,
  parameter int unsigned RST_CNT_W  = 7
) (
  input  logic fclk,
  input  logic rst_n,
  input  logic trig,
  output logic rst_out_n,
  output logic busy
);

  logic [RST_CNT_W-1:0] cnt;
  logic [RST_CNT_W-1:0] cnt_nxt;

  // Reload on trigger (restarts an active pulse), otherwise count down to zero and hold.
  always_comb begin
    cnt_nxt = cnt;
    if (trig) begin
      cnt_nxt = RST_CNT_W'(RST_CYCLES);
    end else if (cnt != '0) begin
      cnt_nxt = cnt - RST_CNT_W'(1);
    end
  end

  // Counter and registered reset/busy outputs; reset loads a full power-on pulse.
  always_ff @(posedge fclk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= RST_CNT_W'(RST_CYCLES);
      rst_out_n <= 1'b0;
      busy      <= 1'b1;
    end else begin
      cnt       <= cnt_nxt;
      rst_out_n <= (cnt_nxt == '0);
      busy      <= (cnt_nxt != '0);
    end
  end

endmodule

// File: rtl/zports_ctrl.sv
// ZX-bus port window control/status bank: ROM mapping, chip resets, interrupt merge.
module zports_ctrl
  import zports_pkg::*;
#(
  parameter int unsigned RST_CYCLES = 64,
  parameter int unsigned RST_CNT_W  = 7
) (
  input  logic              fclk,
  input  logic              rst_n,
  input  logic              ports_wrena,
  input  logic              ports_wrstb_n,
  input  logic [ADDR_W-1:0] ports_addr,
  input  logic [DATA_W-1:0] ports_wrdata,
  output logic [DATA_W-1:0] ports_rddata,
  output logic [1:0]        rommap_win,
  output logic              rommap_ena,
  output logic              w5300_rst_n,
  output logic              sl811_rst_n,
  input  logic              w5300_int_n,
  input  logic              sl811_intrq,
  output logic              zint_n
);

  logic             strb_meta;
  logic             s_strb_n;
  logic             s_strb_prev;
  wr_hold_t         hold;

  logic             commit_c;
  logic             wr_cfg_c;
  logic             wr_irq_c;
  logic             wr_mask_c;
  logic             trig_w_c;
  logic             trig_sl_c;

  logic             w_busy;
  logic             sl_busy;

  logic             w_int_meta;
  logic             w_int_sync;
  logic             sl_int_meta;
  logic             sl_int_sync;

  logic [IRQ_W-1:0] status;
  logic [IRQ_W-1:0] status_nxt;
  logic [IRQ_W-1:0] mask;

  logic             unused_bits_c;

  // Strobe synchroniser and hold registers; data is sampled every cycle the strobe is low.
  always_ff @(posedge fclk or negedge rst_n) begin
    if (!rst_n) begin
      strb_meta   <= 1'b1;
      s_strb_n    <= 1'b1;
      s_strb_prev <= 1'b1;
      hold        <= '0;
    end else begin
      strb_meta   <= ports_wrstb_n;
      s_strb_n    <= strb_meta;
      s_strb_prev <= s_strb_n;
      if (!s_strb_n) begin
        hold <= '{wrena: ports_wrena, addr: ports_addr, data: ports_wrdata};
      end
    end
  end

  // One commit per strobe, on the synchronised rising edge, for window registers only.
  always_comb begin
    commit_c  = s_strb_n & ~s_strb_prev & hold.wrena & (hold.addr != REG_DATA);
    wr_cfg_c  = commit_c & (hold.addr == REG_CFG);
    wr_irq_c  = commit_c & (hold.addr == REG_IRQ);
    wr_mask_c = commit_c & (hold.addr == REG_MASK);
    trig_w_c  = wr_cfg_c & hold.data[CFG_W_RST];
    trig_sl_c = wr_cfg_c & hold.data[CFG_SL_RST];
  end

  // Reserved CFG bits are accepted and discarded.
  assign unused_bits_c = &{1'b0, hold.data[5], hold.data[3:2]};

  rst_pulse #(
    .RST_CYCLES (RST_CYCLES),
    .RST_CNT_W  (RST_CNT_W)
  ) u_w5300_rst (
    .fclk      (fclk),
    .rst_n     (rst_n),
    .trig      (trig_w_c),
    .rst_out_n (w5300_rst_n),
    .busy      (w_busy)
  );

  rst_pulse #(
    .RST_CYCLES (RST_CYCLES),
    .RST_CNT_W  (RST_CNT_W)
  ) u_sl811_rst (
    .fclk      (fclk),
    .rst_n     (rst_n),
    .trig      (trig_sl_c),
    .rst_out_n (sl811_rst_n),
    .busy      (sl_busy)
  );

  // CFG mapping fields and interrupt mask.
  always_ff @(posedge fclk or negedge rst_n) begin
    if (!rst_n) begin
      rommap_win <= 2'b00;
      rommap_ena <= 1'b0;
      mask       <= '0;
    end else begin
      if (wr_cfg_c) begin
        rommap_win <= hold.data[CFG_WIN_HI:CFG_WIN_LO];
        rommap_ena <= hold.data[CFG_ENA];
      end
      if (wr_mask_c) begin
        mask <= hold.data[IRQ_W-1:0];
      end
    end
  end

  // Interrupt synchronisers, normalised to active-high "asserted".
  always_ff @(posedge fclk or negedge rst_n) begin
    if (!rst_n) begin
      w_int_meta  <= 1'b0;
      w_int_sync  <= 1'b0;
      sl_int_meta <= 1'b0;
      sl_int_sync <= 1'b0;
    end else begin
      w_int_meta  <= ~w5300_int_n;
      w_int_sync  <= w_int_meta;
      sl_int_meta <= sl811_intrq;
      sl_int_sync <= sl_int_meta;
    end
  end

  // Status update: W1C, then level set wins, then a chip in reset forces its bit low.
  always_comb begin
    status_nxt = status;
    if (wr_irq_c) begin
      status_nxt = status & ~hold.data[IRQ_W-1:0];
    end
    if (w_int_sync) begin
      status_nxt[IRQ_W5300] = 1'b1;
    end
    if (sl_int_sync) begin
      status_nxt[IRQ_SL811] = 1'b1;
    end
    if (w_busy) begin
      status_nxt[IRQ_W5300] = 1'b0;
    end
    if (sl_busy) begin
      status_nxt[IRQ_SL811] = 1'b0;
    end
  end

  // Status latch and registered Z80 interrupt request.
  always_ff @(posedge fclk or negedge rst_n) begin
    if (!rst_n) begin
      status <= '0;
      zint_n <= 1'b1;
    end else begin
      status <= status_nxt;
      zint_n <= ~|(status & mask);
    end
  end

  // Combinational read-back mux.
  always_comb begin
    ports_rddata = '0;
    case (ports_addr)
      REG_CFG:  ports_rddata = cfg_rd(rommap_win, rommap_ena, sl_busy, w_busy);
      REG_IRQ:  ports_rddata = {(DATA_W-IRQ_W)'(0), status};
      REG_MASK: ports_rddata = {(DATA_W-IRQ_W)'(0), mask};
      default:  ports_rddata = '0;
    endcase
  end

endmodule
